// File: rtl/seq_gen_1101.sv
// Framed serial generator: each accepted payload word is sent as a 1101 preamble,
// the word MSB first, then a fixed idle gap, feeding a 1101 sequence detector.
module seq_gen_1101 #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_done
);

  localparam int MAX_LEN = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                          : ((GAP > 4) ? GAP : 4);
  localparam int CW = $clog2(MAX_LEN) + 1;

  localparam logic [3:0]    PREAMBLE  = 4'b1101;
  localparam logic [CW-1:0] PRE_LAST  = CW'(3);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;

  // The counter runs down to zero within each state and is reloaded on entry,
  // so a state's length is simply its load value plus one.
  // NOTE: every signal assigned here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CW'(1);
    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (in_valid) begin
          state_nxt = S_PRE;
          cnt_nxt   = PRE_LAST;
          shreg_nxt = in_data;
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          state_nxt = S_DATA;
          cnt_nxt   = DATA_LAST;
        end
      end
      S_DATA: begin
        shreg_nxt = shreg << 1;
        if (cnt == '0) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LAST;
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  // Outputs decode registered state only; nothing here looks at an input.
  always_comb begin
    in_ready   = (state == S_IDLE);
    dout_valid = (state == S_PRE) || (state == S_DATA);
    frame_done = (state == S_GAP) && (cnt == GAP_LAST);
    dout       = 1'b0;
    if (state == S_PRE)       dout = PREAMBLE[cnt[1:0]];
    else if (state == S_DATA) dout = shreg[DATA_W-1];
  end

endmodule

// File: tb/tb_seq_gen_1101.sv
// Self-checking bench for seq_gen_1101: directed scenarios plus random traffic,
// compared each cycle against a queue of expected per-cycle output records.
module tb_seq_gen_1101;

  localparam int DW = 8;
  localparam int GP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          dout;
  logic          dout_valid;
  logic          frame_done;

  always #5 clk = ~clk;

  seq_gen_1101 #(.DATA_W(DW), .GAP(GP)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic d;
    logic v;
    logic fd;
    logic rdy;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          cur;
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            det      = 0;
  int            fd_cnt   = 0;
  int            ncap     = 0;
  logic [3:0]    win      = '0;
  logic [DW+3:0] cap      = '0;
  logic          prev_v   = 1'b0;
  int            pre_starts[$];
  int            fd_before;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r.d = 1'b0; r.v = 1'b0; r.fd = 1'b0; r.rdy = 1'b1;
    return r;
  endfunction

  // A frame is 4 preamble bits, the word MSB first, then GP silent cycles
  // with frame_done on the first; the block is busy throughout.
  task automatic push_frame(input logic [DW-1:0] w);
    logic [3:0] pre;
    rec_t       r;
    pre = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      r.d = pre[3-i]; r.v = 1'b1; r.fd = 1'b0; r.rdy = 1'b0;
      exp_q.push_back(r);
    end
    for (int i = 0; i < DW; i++) begin
      r.d = w[DW-1-i]; r.v = 1'b1; r.fd = 1'b0; r.rdy = 1'b0;
      exp_q.push_back(r);
    end
    for (int i = 0; i < GP; i++) begin
      r.d = 1'b0; r.v = 1'b0; r.fd = (i == 0); r.rdy = 1'b0;
      exp_q.push_back(r);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [DW-1:0] data);
    rst      = r;
    in_valid = v;
    in_data  = data;
    if (r)                exp_q.delete();
    else if (v && cur.rdy) push_frame(data);
    @(posedge clk);
    #1;
    cyc++;
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
    check("in_ready",   in_ready,   cur.rdy);
    check("dout_valid", dout_valid, cur.v);
    check("dout",       dout,       cur.d);
    check("frame_done", frame_done, cur.fd);
    win = {win[2:0], dout};
    if (win == 4'b1101) det++;
    if (frame_done) fd_cnt++;
    if (dout_valid && !prev_v) pre_starts.push_back(cyc);
    prev_v = dout_valid;
    if (dout_valid) begin
      cap = {cap[DW+2:0], dout};
      ncap++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    cur      = idle_rec();

    // Reset held two cycles with in_valid high: nothing may be accepted.
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'h5A);
    step(1'b0, 1'b0, 8'h00);
    check("reset_no_valid_bits", ncap, 0);

    // Single frame of 8'hA5.
    ncap = 0; cap = '0; fd_before = fd_cnt;
    step(1'b0, 1'b1, 8'hA5);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    check("a5_stream", cap, 12'hDA5);
    check("a5_nbits",  ncap, 12);
    check("a5_one_fd", fd_cnt - fd_before, 1);

    // Busy-ignore: a word offered mid-payload must not disturb or queue.
    ncap = 0; cap = '0;
    step(1'b0, 1'b1, 8'h0F);
    repeat (5) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    repeat (20) step(1'b0, 1'b0, 8'h00);
    check("busy_stream", cap, 12'hD0F);
    check("busy_nbits",  ncap, 12);

    // Back-to-back with in_valid held: preambles exactly 15 cycles apart.
    pre_starts.delete(); ncap = 0; cap = '0;
    step(1'b0, 1'b1, 8'hD0);
    repeat (15) step(1'b0, 1'b1, 8'h3C);
    repeat (16) step(1'b0, 1'b0, 8'h00);
    check("b2b_nframes", pre_starts.size(), 2);
    if (pre_starts.size() == 2)
      check("b2b_period", pre_starts[1] - pre_starts[0], 15);
    check("b2b_last_stream", cap, 12'hD3C);
    check("b2b_nbits", ncap, 24);

    // Reset during the third payload bit aborts the frame silently.
    fd_before = fd_cnt;
    step(1'b0, 1'b1, 8'hA5);
    repeat (6) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (10) step(1'b0, 1'b0, 8'h00);
    check("abort_no_fd", fd_cnt - fd_before, 0);
    ncap = 0; cap = '0;
    step(1'b0, 1'b1, 8'h81);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    check("after_abort_stream", cap, 12'hD81);
    check("after_abort_nbits",  ncap, 12);

    // Loopback into a 1101 detector: payload bits are sent unstuffed.
    win = '0; det = 0;
    step(1'b0, 1'b1, 8'h00);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    check("loop_00_detects", det, 1);
    det = 0;
    step(1'b0, 1'b1, 8'hDD);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    check("loop_dd_detects", det, 3);

    // Random traffic with occasional resets.
    repeat (400) step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, DW'($urandom));
    repeat (20) step(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_gen_1101.md
SEQ_GEN_1101 -- requirements
Module: seq_gen_1101

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the number of payload bits per frame (legal range 1..32).
REQ-002 SHALL have parameter GAP, default 2, meaning the number of idle cycles after each frame's payload (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer has a payload word on in_data.
REQ-006 SHALL have port in_data, input, DATA_W bits: the payload word, transmitted MSB first.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a payload this cycle.
REQ-008 SHALL have port dout, output, 1 bit: the serial bit stream, fed to the 1101 sequence detector's input.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout carries a preamble or payload bit this cycle.
REQ-010 SHALL have port frame_done, output, 1 bit: a one-cycle pulse marking the end of a frame.

Function
REQ-011 SHALL be a Moore FSM whose outputs (dout, dout_valid, in_ready, frame_done) are all driven from registers or decoded from state only, with no combinational path from any input to any output.
REQ-012 SHALL implement four states:
- IDLE
- PRE (4 cycles)
- DATA (DATA_W cycles)
- GAP (GAP cycles)
REQ-013 SHALL behave as follows in IDLE: in_ready=1, dout=0, dout_valid=0.
REQ-014 SHALL complete a handshake when in_valid=1 and in_ready=1 at a rising edge, and on that edge SHALL capture in_data into a shift register and move to PRE.
REQ-015 SHALL emit preamble bits 1,1,0,1 on dout in PRE, one per cycle, with dout_valid=1, starting in the cycle immediately after the handshake edge (latency 1 cycle).
REQ-016 SHALL emit the captured word MSB first on dout in DATA, one bit per cycle, with dout_valid=1.
REQ-017 SHALL hold dout=0 and dout_valid=0 in GAP.
REQ-018 SHALL assert frame_done only in the first GAP cycle.
REQ-019 SHALL return to IDLE after the last GAP cycle.
REQ-020 SHALL hold in_ready=0 in PRE, DATA and GAP; in_valid and in_data SHALL be ignored there, with no capture and no queuing.
REQ-021 SHALL have a fixed frame period from handshake to the next possible handshake of 4+DATA_W+GAP+1 cycles; back-to-back frames SHALL be separated by exactly one IDLE cycle when in_valid is held high.
REQ-022 SHALL use a preamble/payload bit counter of width ceil(log2(max(4,DATA_W,GAP)))+1 that reloads on every state entry and never wraps within a state.
REQ-023 SHALL NOT stuff or escape payload bits: payload containing 1101 is transmitted verbatim, and the framing contract belongs to the receiver.
REQ-024 SHALL make the captured word immune to in_data changes after the handshake edge.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, force the FSM to IDLE, clear the shift register and counter, and drive in_ready=1, dout=0, dout_valid=0, frame_done=0 from the following cycle on.
REQ-026 SHALL give rst priority over a simultaneous handshake: the word is dropped and not transmitted.
REQ-027 SHALL abort any frame in progress when rst is asserted mid-frame (PRE/DATA/GAP), with no frame_done pulse for the aborted frame.

Verification
REQ-028 SHALL be covered by a reset scenario: rst=1 for 2 cycles with in_valid=1 -> no dout_valid, in_ready=1 after release, dout=0.
REQ-029 SHALL be covered by a single-frame scenario: in_data=8'hA5 handshake -> dout 1,1,0,1,1,0,1,0,0,1,0,1 with dout_valid=1 for 12 cycles, then 2 cycles dout=0/dout_valid=0, frame_done pulse in the first of them, then in_ready=1.
REQ-030 SHALL be covered by a busy-ignore scenario: in_valid pulsed with in_data=8'hFF during DATA of an 8'h0F frame -> the stream is unaffected, and no second frame follows.
REQ-031 SHALL be covered by a back-to-back scenario: in_valid held high with 8'hD0 then 8'h3C -> two frames, each preamble starting 15 cycles apart, each payload bit-exact.
REQ-032 SHALL be covered by a mid-frame reset scenario: rst=1 on the 3rd payload bit of 8'hA5 -> dout_valid=0 next cycle, no frame_done, and a fresh 8'h81 frame afterwards is bit-exact.
REQ-033 SHALL be covered by a loopback scenario: output fed to seqdetect_1101_moore with payloads 8'h00 and 8'hDD -> the detector pulses once per preamble for 8'h00; the extra detections for 8'hDD are documented as expected per REQ-023.
